// File: rtl/ads42_spi_pkg.sv
// Shared constants and state encoding for the ADS42-style SPI register responder.
// Frame layout, MSB first: {R/W, ADDR[6:0], DATA[7:0]}.
// Imported by ads42_spi_slave.
package ads42_spi_pkg;

   localparam int FRAME_W = 16;   // total bits per frame
   localparam int CMD_W   = 8;    // R/W + address byte
   localparam int RW_BIT  = 15;   // R/W flag position within the frame

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_DATA = 2'd2,
      S_WAIT = 2'd3
   } state_e;

endpackage

// File: rtl/ads42_spi_sync_edge.sv
// Purpose: 2-flop synchroniser for one asynchronous SPI pin, plus edge detect.
// Latency: o_sync is 2 sys_clk cycles behind the pin; edges flag on the cycle o_sync changes.
// Backpressure: none; free-running sampler.
// Ports: sys_clk/rst_n clock and async active-low reset; i_async raw pin;
//        o_sync synchronised level; o_rise/o_fall one-cycle edge strobes.
module ads42_spi_sync_edge #(
   parameter logic RST_VAL = 1'b0   // idle level of the pin, so reset creates no false edge
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= i_async;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Edges compare the 2nd (newest safe) and 3rd flops.
   assign o_sync = s2_q;
   assign o_rise = s2_q & ~s3_q;
   assign o_fall = ~s2_q & s3_q;

endmodule

// File: rtl/ads42_spi_slave.sv
// Purpose: SPI responder for 16-bit {R/W, ADDR, DATA} frames with a local register bank.
// Latency: write/read-done pulses 1 sys_clk after the synchronised 16th SCLK rise; MISO ~3 cycles after SCLK fall.
// Backpressure: none; SCLK must be <= sys_clk/8, frames are never stalled.
// Ports: sys_clk, rst_n (async active-low); i_cs_n/i_spi_clk/i_mosi/o_miso SPI pins;
//        o_wr_vld/o_wr_addr/o_wr_dat write report; o_rd_done, o_frame_err pulses;
//        i_loc_addr/o_loc_dat combinational fabric-side register read.
// Build option: define ADS42_SPI_SLV_READBACK_EN to drive register contents on MISO
//        for read frames; otherwise MISO is tied low and read frames only pulse o_rd_done.
module ads42_spi_slave
   import ads42_spi_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 8,
   parameter int REG_NUM = 16
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic              i_cs_n,
   input  logic              i_spi_clk,
   input  logic              i_mosi,
   output logic              o_miso,
   output logic              o_wr_vld,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_dat,
   output logic              o_rd_done,
   output logic              o_frame_err,
   input  logic [ADDR_W-1:0] i_loc_addr,
   output logic [DATA_W-1:0] o_loc_dat
);

   // ---------------- pin synchronisation ----------------
   logic sclk_rise, sclk_fall, sclk_lvl_unused;
   logic cs_lvl, cs_fall, cs_rise_unused;
   logic mosi_s1_q, mosi_s2_q;

   ads42_spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .i_async (i_spi_clk),
      .o_sync  (sclk_lvl_unused),
      .o_rise  (sclk_rise),
      .o_fall  (sclk_fall)
   );

   ads42_spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .i_async (i_cs_n),
      .o_sync  (cs_lvl),
      .o_rise  (cs_rise_unused),
      .o_fall  (cs_fall)
   );

   // MOSI taken from its 2nd flop, the same stage that feeds the SCLK edge detect.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= i_mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   // ---------------- state ----------------
   state_e              state_q, state_d;
   logic [4:0]          bit_cnt_q, bit_cnt_d;
   logic [CMD_W-2:0]    shift_q, shift_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_vld_q, wr_vld_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_dat_q, wr_dat_d;
   logic                rd_done_q, rd_done_d;
   logic                frame_err_q, frame_err_d;
   logic [DATA_W-1:0]   regs_q [REG_NUM];
   logic [DATA_W-1:0]   regs_d [REG_NUM];

   // Byte completed by the current rising edge: seven earlier bits plus this one.
   logic [CMD_W-1:0]    byte_in;
   assign byte_in = {shift_q, mosi_s2_q};

`ifdef ADS42_SPI_SLV_READBACK_EN
   logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
   logic                miso_q, miso_d;
   logic [DATA_W-1:0]   cmd_rd_dat;

   // Register addressed by the command byte being completed; 0 outside the bank.
   always_comb begin
      cmd_rd_dat = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (byte_in[ADDR_W-1:0] == ADDR_W'(i)) cmd_rd_dat = regs_q[i];
      end
   end
`else
   logic sclk_fall_unused;
   assign sclk_fall_unused = sclk_fall;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wr_vld_d    = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_dat_d    = wr_dat_q;
      rd_done_d   = 1'b0;
      frame_err_d = 1'b0;
      regs_d      = regs_q;
`ifdef ADS42_SPI_SLV_READBACK_EN
      rd_shift_d  = rd_shift_q;
      miso_d      = miso_q;
`endif

      case (state_q)
         S_IDLE: begin
`ifdef ADS42_SPI_SLV_READBACK_EN
            miso_d = 1'b0;
`endif
            if (cs_fall) begin
               state_d   = S_CMD;
               bit_cnt_d = '0;
               shift_d   = '0;
`ifdef ADS42_SPI_SLV_READBACK_EN
               rd_shift_d = '0;
`endif
            end
         end

         S_CMD: begin
            if (cs_lvl) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end else if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 5'd1;
               shift_d   = byte_in[CMD_W-2:0];
               if (bit_cnt_q == 5'(CMD_W - 1)) begin
                  rw_d    = byte_in[RW_BIT - CMD_W];
                  addr_d  = byte_in[ADDR_W-1:0];
                  state_d = S_DATA;
`ifdef ADS42_SPI_SLV_READBACK_EN
                  // Writes load zeros so MISO stays low through the data phase.
                  rd_shift_d = byte_in[RW_BIT - CMD_W] ? cmd_rd_dat : '0;
`endif
               end
            end
         end

         S_DATA: begin
            if (cs_lvl) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
`ifdef ADS42_SPI_SLV_READBACK_EN
               miso_d      = 1'b0;
`endif
            end else if (sclk_rise) begin
               bit_cnt_d = bit_cnt_q + 5'd1;
               shift_d   = byte_in[CMD_W-2:0];
               if (bit_cnt_q == 5'(FRAME_W - 1)) begin
                  state_d = S_WAIT;
                  if (rw_q) begin
                     rd_done_d = 1'b1;
                  end else begin
                     // Reported even when the address misses the bank.
                     wr_vld_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_dat_d  = byte_in;
                     for (int i = 0; i < REG_NUM; i++) begin
                        if (addr_q == ADDR_W'(i)) regs_d[i] = byte_in;
                     end
                  end
               end
`ifdef ADS42_SPI_SLV_READBACK_EN
            end else if (sclk_fall) begin
               // Falls 8..15 land here, presenting bits 7..0 for master rises 9..16.
               miso_d     = rd_shift_q[DATA_W-1];
               rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
`endif
            end
         end

         S_WAIT: begin
`ifdef ADS42_SPI_SLV_READBACK_EN
            miso_d = 1'b0;
`endif
            if (cs_lvl) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wr_vld_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_dat_q    <= '0;
         rd_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wr_vld_q    <= wr_vld_d;
         wr_addr_q   <= wr_addr_d;
         wr_dat_q    <= wr_dat_d;
         rd_done_q   <= rd_done_d;
         frame_err_q <= frame_err_d;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
      end
   end

`ifdef ADS42_SPI_SLV_READBACK_EN
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_shift_q <= '0;
         miso_q     <= 1'b0;
      end else begin
         rd_shift_q <= rd_shift_d;
         miso_q     <= miso_d;
      end
   end
   assign o_miso = miso_q;
`else
   assign o_miso = 1'b0;
`endif

   assign o_wr_vld    = wr_vld_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_dat    = wr_dat_q;
   assign o_rd_done   = rd_done_q;
   assign o_frame_err = frame_err_q;

   // Fabric-side read port; addresses outside the bank read as 0.
   always_comb begin
      o_loc_dat = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (i_loc_addr == ADDR_W'(i)) o_loc_dat = regs_q[i];
      end
   end

endmodule

// File: tb/tb_ads42_spi_slave.sv
// Directed bench for ads42_spi_slave: write, read-back, out-of-range, abort,
// mid-frame reset and over-long frames, with hand-computed expectations.
module tb_ads42_spi_slave;

   logic       sys_clk;
   logic       rst_n;
   logic       cs_n;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       wr_vld;
   logic [6:0] wr_addr;
   logic [7:0] wr_dat;
   logic       rd_done;
   logic       frame_err;
   logic [6:0] loc_addr;
   logic [7:0] loc_dat;

   int n_chk = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int err_cnt = 0;

`ifdef ADS42_SPI_SLV_READBACK_EN
   localparam logic [31:0] EXP_RD3 = 32'h0000_00A5;
`else
   localparam logic [31:0] EXP_RD3 = 32'h0000_0000;
`endif

   ads42_spi_slave dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .i_cs_n      (cs_n),
      .i_spi_clk   (sclk),
      .i_mosi      (mosi),
      .o_miso      (miso),
      .o_wr_vld    (wr_vld),
      .o_wr_addr   (wr_addr),
      .o_wr_dat    (wr_dat),
      .o_rd_done   (rd_done),
      .o_frame_err (frame_err),
      .i_loc_addr  (loc_addr),
      .o_loc_dat   (loc_dat)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Pulse counters: a pulse wider than one cycle shows up as an extra count.
   always @(negedge sys_clk) begin
      if (wr_vld)    wr_cnt  = wr_cnt + 1;
      if (rd_done)   rd_cnt  = rd_cnt + 1;
      if (frame_err) err_cnt = err_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic loc_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
      loc_addr = a;
      #1;
      check(tag, {24'h0, loc_dat}, {24'h0, exp});
   endtask

   // Master: 1 MHz SCLK, MOSI changes while SCLK low, MISO sampled at each rise.
   task automatic spi_frame(input logic [15:0] f, input int n_edges, input bit end_cs,
                            output logic [31:0] cap);
      cap = '0;
      @(negedge sys_clk);
      cs_n = 1'b0;
      for (int i = 0; i < n_edges; i++) begin
         mosi = (i < 16) ? f[15 - i] : 1'b0;
         #500;
         sclk = 1'b1;
         cap  = {cap[30:0], miso};
         #500;
         sclk = 1'b0;
      end
      #500;
      mosi = 1'b0;
      if (end_cs) begin
         cs_n = 1'b1;
         #1000;
      end
   endtask

   logic [31:0] cap;
   int w0, r0, e0;

   initial begin
      rst_n    = 1'b0;
      cs_n     = 1'b1;
      sclk     = 1'b0;
      mosi     = 1'b0;
      loc_addr = '0;
      repeat (5) @(negedge sys_clk);

      // Reset state
      check("rst_miso",      {31'h0, miso},      32'h0);
      check("rst_wr_vld",    {31'h0, wr_vld},    32'h0);
      check("rst_wr_addr",   {25'h0, wr_addr},   32'h0);
      check("rst_wr_dat",    {24'h0, wr_dat},    32'h0);
      check("rst_rd_done",   {31'h0, rd_done},   32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      loc_chk("rst_loc3", 7'd3, 8'h00);
      @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);

      // 1: write 0xA5 to reg 3
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(16'h03A5, 16, 1'b1, cap);
      check("t1_wr_pulses", wr_cnt - w0, 1);
      check("t1_wr_addr", {25'h0, wr_addr}, 32'h3);
      check("t1_wr_dat",  {24'h0, wr_dat},  32'hA5);
      check("t1_no_err",  err_cnt - e0, 0);
      check("t1_miso",    cap, 32'h0);
      loc_chk("t1_loc3", 7'd3, 8'hA5);

      // 2: read reg 3
      w0 = wr_cnt; r0 = rd_cnt;
      spi_frame(16'h8300, 16, 1'b1, cap);
      check("t2_miso_bits", cap, EXP_RD3);
      check("t2_rd_pulses", rd_cnt - r0, 1);
      check("t2_no_write",  wr_cnt - w0, 0);
      loc_chk("t2_loc3", 7'd3, 8'hA5);
      check("t2_miso_idle", {31'h0, miso}, 32'h0);

      // 3: write to address outside the bank, then read it
      w0 = wr_cnt;
      spi_frame(16'h1477, 16, 1'b1, cap);
      check("t3_wr_pulses", wr_cnt - w0, 1);
      check("t3_wr_addr", {25'h0, wr_addr}, 32'h14);
      check("t3_wr_dat",  {24'h0, wr_dat},  32'h77);
      loc_chk("t3_loc14", 7'h14, 8'h00);
      loc_chk("t3_loc4_alias", 7'h04, 8'h00);
      loc_chk("t3_loc3_kept", 7'h03, 8'hA5);
      r0 = rd_cnt;
      spi_frame(16'h9400, 16, 1'b1, cap);
      check("t3_rd_miso",  cap, 32'h0);
      check("t3_rd_pulse", rd_cnt - r0, 1);

      // 4: abort after 11 edges, then a full frame
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(16'h0555, 11, 1'b1, cap);
      check("t4_err_pulse", err_cnt - e0, 1);
      check("t4_no_write",  wr_cnt - w0, 0);
      loc_chk("t4_loc5_abort", 7'd5, 8'h00);
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(16'h0555, 16, 1'b1, cap);
      check("t4_wr_pulses", wr_cnt - w0, 1);
      check("t4_no_err",    err_cnt - e0, 0);
      loc_chk("t4_loc5", 7'd5, 8'h55);

      // 5: reset after 10 edges of a write frame
      spi_frame(16'h0377, 10, 1'b0, cap);
      @(negedge sys_clk);
      rst_n = 1'b0;
      #1;
      check("t5_wr_addr",   {25'h0, wr_addr},   32'h0);
      check("t5_wr_dat",    {24'h0, wr_dat},    32'h0);
      check("t5_wr_vld",    {31'h0, wr_vld},    32'h0);
      check("t5_frame_err", {31'h0, frame_err}, 32'h0);
      loc_chk("t5_loc3", 7'd3, 8'h00);
      loc_chk("t5_loc5", 7'd5, 8'h00);
      cs_n = 1'b1;
      repeat (10) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (10) @(negedge sys_clk);
      spi_frame(16'h0112, 16, 1'b1, cap);
      check("t5_wr_addr_after", {25'h0, wr_addr}, 32'h1);
      loc_chk("t5_loc1", 7'd1, 8'h12);

      // 6: 20 SCLK edges in one write frame
      w0 = wr_cnt; e0 = err_cnt;
      spi_frame(16'h0242, 20, 1'b1, cap);
      check("t6_wr_pulses", wr_cnt - w0, 1);
      check("t6_no_err",    err_cnt - e0, 0);
      check("t6_miso",      cap, 32'h0);
      check("t6_wr_dat",    {24'h0, wr_dat}, 32'h42);
      loc_chk("t6_loc2", 7'd2, 8'h42);
      loc_chk("t6_loc1", 7'd1, 8'h12);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
